// File: rtl/ucsbece152a_taillights_seq.sv
// Sequential taillight controller: mode/step sequencer with
// brake and PWM-dimmed running-light overlays, registered outputs.
module ucsbece152a_taillights_seq #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 4,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                left_i,
  input  logic                right_i,
  input  logic                hazard_i,
  input  logic                brake_i,
  input  logic                runlights_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic [2*LAMPS-1:0]  lights_o,
  output logic [1:0]          mode_o
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SW-1:0] STEP_MAX = SW'(LAMPS);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_e;

  mode_e               mode;
  mode_e               mode_nx;
  mode_e               req;
  logic [SW-1:0]       step;
  logic [SW-1:0]       step_nx;
  logic [TW-1:0]       tick;
  logic [TW-1:0]       tick_nx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [LAMPS-1:0]    bar;
  logic [LAMPS-1:0]    bar_rev;
  logic [2*LAMPS-1:0]  lit;
  logic [2*LAMPS-1:0]  brk;
  logic [2*LAMPS-1:0]  lights_nx;
  logic                dim;

  always_comb begin
    req = IDLE;
    if (hazard_i | (left_i & right_i)) req = HAZARD;
    else if (left_i)                   req = LEFT;
    else if (right_i)                  req = RIGHT;
  end

  always_comb begin
    mode_nx = mode;
    step_nx = step;
    tick_nx = tick;
    if (req != mode) begin
      mode_nx = req;
      tick_nx = '0;
      step_nx = (req == LEFT || req == RIGHT) ? SW'(1) : '0;
    end else if (mode == IDLE) begin
      step_nx = '0;
      tick_nx = '0;
    end else if (tick == TICK_MAX) begin
      tick_nx = '0;
      if (mode == HAZARD)
        step_nx = (step == '0) ? SW'(1) : '0;
      else
        step_nx = (step == STEP_MAX) ? '0 : step + 1'b1;
    end else begin
      tick_nx = tick + 1'b1;
    end
  end

  // bar[i] lights the i-th lamp counted from the inside out
  always_comb begin
    bar     = '0;
    bar_rev = '0;
    for (int i = 0; i < LAMPS; i++) begin
      bar[i]               = (i < int'(step));
      bar_rev[LAMPS-1-i]   = (i < int'(step));
    end
  end

  always_comb begin
    lit = '0;
    unique case (mode)
      LEFT:    lit = {bar, {LAMPS{1'b0}}};
      RIGHT:   lit = {{LAMPS{1'b0}}, bar_rev};
      HAZARD:  lit = (step == '0) ? {2*LAMPS{1'b1}} : '0;
      IDLE:    lit = '0;
    endcase
  end

  always_comb begin
    brk = lit;
    if (brake_i) begin
      unique case (mode)
        LEFT:    brk = lit | {{LAMPS{1'b0}}, {LAMPS{1'b1}}};
        RIGHT:   brk = lit | {{LAMPS{1'b1}}, {LAMPS{1'b0}}};
        default: brk = {2*LAMPS{1'b1}};
      endcase
    end
  end

  assign dim       = runlights_i & (pwm_cnt < duty_i);
  assign lights_nx = brk | {2*LAMPS{dim}};
  assign mode_o    = mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= IDLE;
      step     <= '0;
      tick     <= '0;
      pwm_cnt  <= '0;
      lights_o <= '0;
    end else begin
      mode     <= mode_nx;
      step     <= step_nx;
      tick     <= tick_nx;
      pwm_cnt  <= pwm_cnt + 1'b1;
      lights_o <= lights_nx;
    end
  end

endmodule

// File: tb/tb_ucsbece152a_taillights_seq.sv
// Scenario bench for the sequential taillight controller
// (LAMPS=3, TICK_DIV=2, PWM_BITS=2).
module tb_ucsbece152a_taillights_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       left_i = 1'b0;
  logic       right_i = 1'b0;
  logic       hazard_i = 1'b0;
  logic       brake_i = 1'b0;
  logic       runlights_i = 1'b0;
  logic [1:0] duty_i = 2'd0;
  logic [5:0] lights_o;
  logic [1:0] mode_o;

  int tests = 0;
  int fails = 0;

  logic [5:0] exp_q [$];
  logic [1:0] mode_q [$];

  ucsbece152a_taillights_seq #(
    .LAMPS(3),
    .TICK_DIV(2),
    .PWM_BITS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .left_i(left_i),
    .right_i(right_i),
    .hazard_i(hazard_i),
    .brake_i(brake_i),
    .runlights_i(runlights_i),
    .duty_i(duty_i),
    .lights_o(lights_o),
    .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    left_i      = 1'b0;
    right_i     = 1'b0;
    hazard_i    = 1'b0;
    brake_i     = 1'b0;
    runlights_i = 1'b0;
    duty_i      = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (lights_o !== 6'd0) begin
      fails++;
      $display("FAIL reset_lights: got %b want %b", lights_o, 6'd0);
    end
    tests++;
    if (mode_o !== 2'd0) begin
      fails++;
      $display("FAIL reset_mode: got %0d want 0", mode_o);
    end
  endtask

  task automatic test_left();
    logic [5:0] e [18];
    logic [5:0] got;
    logic [1:0] gm;
    e = '{6'd0, 6'd8, 6'd8, 6'd24, 6'd24, 6'd56, 6'd56, 6'd0, 6'd0,
          6'd8, 6'd8, 6'd24, 6'd24, 6'd56, 6'd56, 6'd0, 6'd0, 6'd8};
    do_reset();
    left_i = 1'b1;
    for (int k = 0; k < 18; k++) begin
      exp_q.push_back(e[k]);
      mode_q.push_back(2'd1);
      @(negedge clk);
      got = exp_q.pop_front();
      gm  = mode_q.pop_front();
      tests++;
      if (lights_o !== got) begin
        fails++;
        $display("FAIL left[%0d]: lights got %b want %b", k, lights_o, got);
      end
      tests++;
      if (mode_o !== gm) begin
        fails++;
        $display("FAIL left_mode[%0d]: got %0d want %0d", k, mode_o, gm);
      end
    end
  endtask

  task automatic test_right_brake();
    logic [5:0] e [12];
    logic [5:0] got;
    logic [1:0] gm;
    e = '{6'd0, 6'd4, 6'd4, 6'd62, 6'd62, 6'd63, 6'd63,
          6'd56, 6'd56, 6'd60, 6'd60, 6'd62};
    do_reset();
    right_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) brake_i = 1'b1;
      exp_q.push_back(e[k]);
      mode_q.push_back(2'd2);
      @(negedge clk);
      got = exp_q.pop_front();
      gm  = mode_q.pop_front();
      tests++;
      if (lights_o !== got) begin
        fails++;
        $display("FAIL right_brake[%0d]: lights got %b want %b", k, lights_o, got);
      end
      tests++;
      if (mode_o !== gm) begin
        fails++;
        $display("FAIL right_mode[%0d]: got %0d want %0d", k, mode_o, gm);
      end
    end
  endtask

  task automatic test_hazard();
    logic [5:0] e [12];
    logic [5:0] got;
    logic [1:0] gm;
    e = '{6'd0, 6'd63, 6'd63, 6'd0, 6'd0, 6'd63, 6'd63, 6'd0,
          6'd63, 6'd63, 6'd63, 6'd63};
    do_reset();
    hazard_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) brake_i = 1'b1;
      exp_q.push_back(e[k]);
      mode_q.push_back(2'd3);
      @(negedge clk);
      got = exp_q.pop_front();
      gm  = mode_q.pop_front();
      tests++;
      if (lights_o !== got) begin
        fails++;
        $display("FAIL hazard[%0d]: lights got %b want %b", k, lights_o, got);
      end
      tests++;
      if (mode_o !== gm) begin
        fails++;
        $display("FAIL hazard_mode[%0d]: got %0d want %0d", k, mode_o, gm);
      end
    end
  endtask

  task automatic test_left_right();
    logic [5:0] e [8];
    logic [5:0] got;
    logic [1:0] gm;
    e = '{6'd0, 6'd63, 6'd63, 6'd0, 6'd0, 6'd63, 6'd63, 6'd0};
    do_reset();
    left_i  = 1'b1;
    right_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(e[k]);
      mode_q.push_back(2'd3);
      @(negedge clk);
      got = exp_q.pop_front();
      gm  = mode_q.pop_front();
      tests++;
      if (lights_o !== got) begin
        fails++;
        $display("FAIL left_right[%0d]: lights got %b want %b", k, lights_o, got);
      end
      tests++;
      if (mode_o !== gm) begin
        fails++;
        $display("FAIL left_right_mode[%0d]: got %0d want %0d", k, mode_o, gm);
      end
    end
  endtask

  task automatic test_runlights();
    logic [5:0] e [16];
    logic [5:0] got;
    logic [1:0] gm;
    e = '{6'd63, 6'd63, 6'd0, 6'd0, 6'd63, 6'd63, 6'd0, 6'd0,
          6'd0, 6'd0, 6'd0, 6'd0,
          6'd63, 6'd63, 6'd63, 6'd0};
    do_reset();
    runlights_i = 1'b1;
    duty_i      = 2'd2;
    for (int k = 0; k < 16; k++) begin
      if (k == 8)  duty_i = 2'd0;
      if (k == 12) duty_i = 2'd3;
      exp_q.push_back(e[k]);
      mode_q.push_back(2'd0);
      @(negedge clk);
      got = exp_q.pop_front();
      gm  = mode_q.pop_front();
      tests++;
      if (lights_o !== got) begin
        fails++;
        $display("FAIL runlights[%0d]: lights got %b want %b", k, lights_o, got);
      end
      tests++;
      if (mode_o !== gm) begin
        fails++;
        $display("FAIL runlights_mode[%0d]: got %0d want %0d", k, mode_o, gm);
      end
    end
  endtask

  task automatic test_dim_turn();
    logic [5:0] e [8];
    logic [5:0] got;
    e = '{6'd63, 6'd63, 6'd8, 6'd24, 6'd63, 6'd63, 6'd56, 6'd0};
    do_reset();
    left_i      = 1'b1;
    runlights_i = 1'b1;
    duty_i      = 2'd2;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(e[k]);
      @(negedge clk);
      got = exp_q.pop_front();
      tests++;
      if (lights_o !== got) begin
        fails++;
        $display("FAIL dim_turn[%0d]: lights got %b want %b", k, lights_o, got);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [5:0] e [8];
    logic [1:0] m [8];
    logic [5:0] got;
    logic [1:0] gm;
    e = '{6'd0, 6'd8, 6'd8, 6'd24, 6'd4, 6'd4, 6'd6, 6'd6};
    m = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    do_reset();
    left_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        left_i  = 1'b0;
        right_i = 1'b1;
      end
      exp_q.push_back(e[k]);
      mode_q.push_back(m[k]);
      @(negedge clk);
      got = exp_q.pop_front();
      gm  = mode_q.pop_front();
      tests++;
      if (lights_o !== got) begin
        fails++;
        $display("FAIL switch[%0d]: lights got %b want %b", k, lights_o, got);
      end
      tests++;
      if (mode_o !== gm) begin
        fails++;
        $display("FAIL switch_mode[%0d]: got %0d want %0d", k, mode_o, gm);
      end
    end
  endtask

  task automatic test_restart();
    logic [5:0] e [11];
    logic [1:0] m [11];
    logic [5:0] got;
    logic [1:0] gm;
    e = '{6'd0, 6'd8, 6'd8, 6'd24, 6'd24, 6'd56, 6'd0, 6'd0,
          6'd8, 6'd8, 6'd24};
    m = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1,
          2'd1, 2'd1, 2'd1};
    do_reset();
    left_i = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 5) left_i = 1'b0;
      if (k == 7) left_i = 1'b1;
      exp_q.push_back(e[k]);
      mode_q.push_back(m[k]);
      @(negedge clk);
      got = exp_q.pop_front();
      gm  = mode_q.pop_front();
      tests++;
      if (lights_o !== got) begin
        fails++;
        $display("FAIL restart[%0d]: lights got %b want %b", k, lights_o, got);
      end
      tests++;
      if (mode_o !== gm) begin
        fails++;
        $display("FAIL restart_mode[%0d]: got %0d want %0d", k, mode_o, gm);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] e [3];
    logic [5:0] got;
    e = '{6'd0, 6'd63, 6'd63};
    do_reset();
    hazard_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(e[k]);
      @(negedge clk);
      got = exp_q.pop_front();
      tests++;
      if (lights_o !== got) begin
        fails++;
        $display("FAIL async_pre[%0d]: lights got %b want %b", k, lights_o, got);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (lights_o !== 6'd0) begin
      fails++;
      $display("FAIL async_lights: got %b want %b", lights_o, 6'd0);
    end
    tests++;
    if (mode_o !== 2'd0) begin
      fails++;
      $display("FAIL async_mode: got %0d want 0", mode_o);
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (lights_o !== 6'd0 || mode_o !== 2'd0) begin
        fails++;
        $display("FAIL async_post[%0d]: lights %b mode %0d want 000000 mode 0",
                 k, lights_o, mode_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_right_brake();
    test_hazard();
    test_left_right();
    test_runlights();
    test_dim_turn();
    test_mode_switch();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
